cache_line_refill_unit: RTL and testbench

- Sits directly downstream of the cache datapath, between the cache and the 4B memory port.
- Turns one line-level request (refill or writeback of a 64-byte line) into 16 word-sized mem_req_4B_t transactions. Collects the 16 mem_resp_4B_t responses.
- For a refill, assembles the 512-bit line and returns it to the cache in one line response. For a writeback, returns a completion.
- Decouples the cache FSM from per-word memory handshaking.

---
 rtl/cache_line_refill_unit.sv | 142 ++++++++++++++
 tb/tb_cache_line_refill_unit.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/cache_line_refill_unit.sv
// Splits a 64-byte line refill/writeback into 16 word transactions on the 4B
// memory port and hands the cache one line-level completion.
//
// state | meaning
// IDLE  | waiting for a line request
// ISSUE | sending word requests, collecting any early responses
// DRAIN | all words issued, waiting for remaining responses
// RESP  | presenting the line response until the cache accepts it
module cache_line_refill_unit #(
  parameter int p_words_per_line = 16,
  parameter int p_line_addr_bits = 26
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        line_req_val,
  output logic                        line_req_rdy,
  input  logic                        line_req_wb,
  input  logic [p_line_addr_bits-1:0] line_req_addr,
  input  logic [511:0]                line_req_data,
  output logic                        line_resp_val,
  input  logic                        line_resp_rdy,
  output logic                        line_resp_wb,
  output logic [511:0]                line_resp_data,
  output logic                        memreq_val,
  input  logic                        memreq_rdy,
  output logic [76:0]                 memreq_msg,
  input  logic                        memresp_val,
  output logic                        memresp_rdy,
  input  logic [46:0]                 memresp_msg
);

  if (p_words_per_line != 16) begin : g_bad_words_per_line
    $error("cache_line_refill_unit: p_words_per_line must be 16");
  end

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, RESP} state_t;

  state_t                        state;
  logic [4:0]                    issue_cnt;
  logic [4:0]                    recv_cnt;
  logic                          wb_r;
  logic [p_line_addr_bits-1:0]   addr_r;
  logic [15:0][31:0]             data_r;
  logic [15:0][31:0]             buf_r;

  logic       req_fire;
  logic       resp_fire;
  logic [4:0] recv_next;
  logic [3:0] resp_word;

  assign req_fire  = memreq_val && memreq_rdy;
  assign resp_fire = memresp_val && memresp_rdy;
  assign recv_next = recv_cnt + {4'b0, resp_fire};
  assign resp_word = memresp_msg[39:36];

  // mem_req_4B_t: {type[2:0], opaque[7:0], addr[31:0], len[1:0], data[31:0]}
  assign memreq_msg = {2'b00, wb_r,
                       4'b0000, issue_cnt[3:0],
                       addr_r, issue_cnt[3:0], 2'b00,
                       2'b00,
                       wb_r ? data_r[issue_cnt[3:0]] : 32'h0};

  assign line_resp_wb   = wb_r;
  assign line_resp_data = (line_resp_val && !wb_r) ? buf_r : '0;

  logic unused_resp_fields;
  assign unused_resp_fields = ^{memresp_msg[46:40], memresp_msg[35:32]};

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      issue_cnt     <= '0;
      recv_cnt      <= '0;
      wb_r          <= 1'b0;
      addr_r        <= '0;
      data_r        <= '0;
      buf_r         <= '0;
      line_req_rdy  <= 1'b1;
      line_resp_val <= 1'b0;
      memreq_val    <= 1'b0;
      memresp_rdy   <= 1'b0;
    end else begin
      // Responses are placed by opaque, so out-of-order returns land correctly.
      if (resp_fire) begin
        recv_cnt <= recv_next;
        if (!wb_r) buf_r[resp_word] <= memresp_msg[31:0];
      end

      case (state)
        IDLE: begin
          if (line_req_val && line_req_rdy) begin
            wb_r         <= line_req_wb;
            addr_r       <= line_req_addr;
            data_r       <= line_req_data;
            buf_r        <= '0;
            issue_cnt    <= '0;
            recv_cnt     <= '0;
            line_req_rdy <= 1'b0;
            memreq_val   <= 1'b1;
            memresp_rdy  <= 1'b1;
            state        <= ISSUE;
          end
        end
        ISSUE: begin
          if (req_fire) begin
            issue_cnt <= issue_cnt + 5'd1;
            if (issue_cnt == 5'd15) begin
              memreq_val <= 1'b0;
              if (recv_next == 5'd16) begin
                memresp_rdy   <= 1'b0;
                line_resp_val <= 1'b1;
                state         <= RESP;
              end else begin
                state <= DRAIN;
              end
            end
          end
        end
        DRAIN: begin
          if (recv_next == 5'd16) begin
            memresp_rdy   <= 1'b0;
            line_resp_val <= 1'b1;
            state         <= RESP;
          end
        end
        RESP: begin
          if (line_resp_val && line_resp_rdy) begin
            line_resp_val <= 1'b0;
            line_req_rdy  <= 1'b1;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) assert (!(resp_fire && recv_cnt == 5'd16));
  end

endmodule

// File: tb/tb_cache_line_refill_unit.sv
// Bench for cache_line_refill_unit: table of line operations plus random ones,
// driven against a word-addressed memory model with several response orders.
module tb_cache_line_refill_unit;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         line_req_val = 1'b0;
  logic         line_req_rdy;
  logic         line_req_wb = 1'b0;
  logic [25:0]  line_req_addr = '0;
  logic [511:0] line_req_data = '0;
  logic         line_resp_val;
  logic         line_resp_rdy = 1'b0;
  logic         line_resp_wb;
  logic [511:0] line_resp_data;
  logic         memreq_val;
  logic         memreq_rdy = 1'b0;
  logic [76:0]  memreq_msg;
  logic         memresp_val = 1'b0;
  logic         memresp_rdy;
  logic [46:0]  memresp_msg = '0;

  always #5 clk = ~clk;

  cache_line_refill_unit dut (
    .clk(clk), .reset(reset),
    .line_req_val(line_req_val), .line_req_rdy(line_req_rdy),
    .line_req_wb(line_req_wb), .line_req_addr(line_req_addr),
    .line_req_data(line_req_data),
    .line_resp_val(line_resp_val), .line_resp_rdy(line_resp_rdy),
    .line_resp_wb(line_resp_wb), .line_resp_data(line_resp_data),
    .memreq_val(memreq_val), .memreq_rdy(memreq_rdy), .memreq_msg(memreq_msg),
    .memresp_val(memresp_val), .memresp_rdy(memresp_rdy),
    .memresp_msg(memresp_msg)
  );

  localparam int POL_IDEAL = 0;
  localparam int POL_RAND  = 1;
  localparam int POL_REV   = 2;

  int n_checks = 0;
  int n_errors = 0;

  int unsigned  mem [int unsigned];
  logic [76:0]  pend [$];

  typedef struct {
    logic         wb;
    logic [25:0]  addr;
    logic [511:0] wdata;
    int           pol;
    int           stall;
    int           exp_lat;
    logic         exp_wb;
  } vec_t;

  vec_t vecs [7];

  function automatic void check(string name, logic [511:0] act, logic [511:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  function automatic logic [31:0] mem_rd(logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return a ^ 32'hDEADBEEF;
  endfunction

  function automatic logic [46:0] mk_resp(logic [76:0] rq);
    logic [31:0] d;
    d = rq[74] ? $urandom : mem_rd(rq[65:34]);
    return {rq[76:74], rq[73:66], 2'b00, 2'b00, d};
  endfunction

  task automatic check_reset_outputs(string tag);
    check({tag, "_line_req_rdy"},   line_req_rdy,   1);
    check({tag, "_line_resp_val"},  line_resp_val,  0);
    check({tag, "_memreq_val"},     memreq_val,     0);
    check({tag, "_memresp_rdy"},    memresp_rdy,    0);
    check({tag, "_line_resp_data"}, line_resp_data, 0);
    check({tag, "_line_resp_wb"},   line_resp_wb,   0);
  endtask

  // Called at a negedge with the unit idle; returns at a negedge.
  task automatic do_line(input logic wb, input logic [25:0] la, input logic [511:0] wdata,
                         input int pol, input int stall, input int exp_lat,
                         input logic exp_wb, input int abort_at);
    logic [511:0] exp_line, hold;
    logic [31:0]  base;
    logic [76:0]  exp_req, prev_msg;
    logic         prev_stall, done, give;
    int           issued, recvd, last_resp_cyc, cyc, idx;

    base = {la, 6'b0};
    for (int i = 0; i < 16; i++)
      exp_line[32*i +: 32] = wb ? 32'h0 : mem_rd(base + 32'(4*i));
    check("line_req_rdy_idle", line_req_rdy, 1);
    line_req_val = 1'b1; line_req_wb = wb; line_req_addr = la; line_req_data = wdata;
    line_resp_rdy = 1'b0;
    @(negedge clk);
    cyc = 1;
    line_req_val = 1'b0; line_req_addr = ~la; line_req_data = ~wdata;
    issued = 0; recvd = 0; last_resp_cyc = 0; prev_stall = 1'b0; done = 1'b0;
    prev_msg = '0;

    while (!done && cyc < 3000) begin
      if (abort_at >= 0 && issued == abort_at) begin
        memreq_rdy = 1'b0; memresp_val = 1'b0; reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check_reset_outputs("abort");
        pend.delete();
        return;
      end
      if (line_resp_val) begin
        memresp_val = 1'b0; memreq_rdy = 1'b0;
        if (exp_lat >= 0) check("latency", cyc, exp_lat);
        check("resp_after_last", cyc, last_resp_cyc + 1);
        check("recv_count", recvd, 16);
        check("line_resp_wb", line_resp_wb, exp_wb);
        check("line_resp_data", line_resp_data, exp_line);
        hold = line_resp_data;
        for (int s = 0; s < stall; s++) begin
          line_resp_rdy = 1'b0;
          @(negedge clk);
          check("stall_resp_val", line_resp_val, 1);
          check("stall_resp_data", line_resp_data, hold);
          check("stall_req_rdy", line_req_rdy, 0);
        end
        line_resp_rdy = 1'b1;
        @(negedge clk);
        line_resp_rdy = 1'b0;
        check("resp_val_drop", line_resp_val, 0);
        check("req_rdy_back", line_req_rdy, 1);
        done = 1'b1;
      end else begin
        memresp_val = 1'b0;
        if (pend.size() > 0) begin
          idx = 0;
          give = 1'b1;
          if (pol == POL_RAND) give = ($urandom % 2) == 1;
          if (pol == POL_REV) begin
            give = (issued == 16);
            idx = pend.size() - 1;
          end
          if (give) begin
            memresp_val = 1'b1;
            memresp_msg = mk_resp(pend[idx]);
            if (memresp_rdy) begin
              pend.delete(idx);
              recvd++;
              last_resp_cyc = cyc;
            end
          end
        end
        memreq_rdy = (pol == POL_RAND) ? (($urandom % 2) == 1) : 1'b1;
        if (memreq_val) begin
          if (prev_stall) check("memreq_stable", memreq_msg, prev_msg);
          prev_msg = memreq_msg;
          prev_stall = !memreq_rdy;
          if (memreq_rdy) begin
            exp_req = {2'b00, wb, 4'b0000, 4'(issued), base + 32'(4*issued), 2'b00,
                       wb ? wdata[32*issued +: 32] : 32'h0};
            check("memreq_msg", memreq_msg, exp_req);
            pend.push_back(memreq_msg);
            if (memreq_msg[74]) mem[memreq_msg[65:34]] = memreq_msg[31:0];
            issued++;
          end
        end else begin
          prev_stall = 1'b0;
        end
        @(negedge clk);
        cyc++;
      end
    end

    if (!done) begin
      n_checks++; n_errors++;
      $display("FAIL timeout: no line response after %0d cycles, issued %0d recv %0d",
               cyc, issued, recvd);
      memreq_rdy = 1'b0; memresp_val = 1'b0; reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      pend.delete();
    end
  endtask

  initial begin
    logic [511:0] wd, rd;
    logic         rwb;

    for (int i = 0; i < 16; i++) wd[32*i +: 32] = 32'h100 + 32'(i);
    vecs[0] = '{1'b0, 26'h40, 512'h0, POL_IDEAL, 0, 18, 1'b0};
    vecs[1] = '{1'b1, 26'h80, wd,     POL_IDEAL, 0, 18, 1'b1};
    vecs[2] = '{1'b0, 26'h40, 512'h0, POL_RAND,  0, -1, 1'b0};
    vecs[3] = '{1'b0, 26'h40, 512'h0, POL_REV,   0, -1, 1'b0};
    vecs[4] = '{1'b0, 26'h40, 512'h0, POL_IDEAL, 5, 18, 1'b0};
    vecs[5] = '{1'b0, 26'h80, 512'h0, POL_IDEAL, 0, 18, 1'b0};
    vecs[6] = '{1'b1, 26'h81, ~wd,    POL_REV,   2, -1, 1'b1};

    repeat (3) @(negedge clk);
    reset = 1'b0;
    check_reset_outputs("reset");

    foreach (vecs[v])
      do_line(vecs[v].wb, vecs[v].addr, vecs[v].wdata, vecs[v].pol, vecs[v].stall,
              vecs[v].exp_lat, vecs[v].exp_wb, -1);

    do_line(1'b0, 26'h40, 512'h0, POL_IDEAL, 0, -1, 1'b0, 7);
    do_line(1'b0, 26'h40, 512'h0, POL_IDEAL, 0, 18, 1'b0, -1);

    for (int r = 0; r < 10; r++) begin
      rwb = ($urandom % 2) == 1;
      for (int i = 0; i < 16; i++) rd[32*i +: 32] = $urandom;
      do_line(rwb, 26'(32'h40 + ($urandom % 8)), rd, $urandom_range(0, 2),
              $urandom_range(0, 3), -1, rwb, -1);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
